// File: rtl/mpc_pkg.sv
// Shared definitions for the macro-select configuration controller:
// switch FSM states, register offsets, STATUS bit positions, default base.
package mpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISOLATE = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_RELEASE = 3'd4
    } mpc_state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    localparam int STAT_BUSY_BIT      = 8;
    localparam int STAT_RANGE_ERR_BIT = 9;
    localparam int STAT_BUSY_ERR_BIT  = 10;

    localparam logic [31:0] CFG_BASE_DEFAULT = 32'h3000_0000;

endpackage

// File: rtl/mpc_cfg_wb_regs.sv
// Wishbone classic slave front end: window decode, single-cycle registered
// ack, registered readback, and one-cycle write strobes toward the FSM.
module mpc_cfg_wb_regs
    import mpc_pkg::*;
#(
    parameter int cfg_bits       = 2,
    parameter int WB_data_bits   = 32,
    parameter int WB_addr_bits   = 32,
    parameter int WB_select_bits = 4,
    parameter logic [WB_addr_bits-1:0] CFG_BASE = WB_addr_bits'(CFG_BASE_DEFAULT)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [WB_select_bits-1:0] wbs_sel_i,
    input  logic [WB_data_bits-1:0]   wbs_dat_i,
    input  logic [WB_addr_bits-1:0]   wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [WB_data_bits-1:0]   wbs_dat_o,
    input  logic [cfg_bits-1:0]       pending,
    input  logic [cfg_bits-1:0]       configuration,
    input  logic                      busy,
    input  logic                      range_err,
    input  logic                      busy_err,
    output logic                      ctrl_wr,
    output logic                      status_wr,
    output logic [WB_data_bits-1:0]   wr_data
);

    logic                    hit;
    logic                    take;
    logic                    ack_done;
    logic [1:0]              offset;
    logic [WB_data_bits-1:0] rd_data;
    logic                    unused_bits;

    assign offset = wbs_adr_i[3:2];
    assign hit    = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[WB_addr_bits-1:4] == CFG_BASE[WB_addr_bits-1:4]);
    // A strobe is taken once; ack_done blocks a second ack while it stays up.
    assign take      = hit & ~wbs_ack_o & ~ack_done;
    assign ctrl_wr   = take & wbs_we_i & (offset == OFF_CTRL) & wbs_sel_i[0];
    assign status_wr = take & wbs_we_i & (offset == OFF_STATUS);
    assign wr_data   = wbs_dat_i;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i};

    // Readback mux; reserved offsets read as zero.
    always_comb begin
        rd_data = '0;
        if (offset == OFF_CTRL) begin
            rd_data[cfg_bits-1:0] = pending;
        end else if (offset == OFF_STATUS) begin
            rd_data[cfg_bits-1:0]        = configuration;
            rd_data[STAT_BUSY_BIT]       = busy;
            rd_data[STAT_RANGE_ERR_BIT]  = range_err;
            rd_data[STAT_BUSY_ERR_BIT]   = busy_err;
        end
    end

    // Registered ack and read data; data is zero whenever ack is low.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            ack_done  <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= take;
            ack_done  <= hit & (ack_done | wbs_ack_o);
            wbs_dat_o <= (take & ~wbs_we_i) ? rd_data : '0;
        end
    end

endmodule

// File: rtl/mpc_cfg_ctrl.sv
// Macro-select controller: drains the bus, isolates IO, holds the outgoing
// macro in reset, swaps the select, then holds the incoming macro in reset.
module mpc_cfg_ctrl
    import mpc_pkg::*;
#(
    parameter int user_macros    = 4,
    parameter int cfg_bits       = (user_macros > 1) ? $clog2(user_macros) : 1,
    parameter int WB_data_bits   = 32,
    parameter int WB_addr_bits   = 32,
    parameter int WB_select_bits = 4,
    parameter logic [WB_addr_bits-1:0] CFG_BASE = WB_addr_bits'(CFG_BASE_DEFAULT),
    parameter int GUARD_CYCLES   = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [WB_select_bits-1:0] wbs_sel_i,
    input  logic [WB_data_bits-1:0]   wbs_dat_i,
    input  logic [WB_addr_bits-1:0]   wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [WB_data_bits-1:0]   wbs_dat_o,
    output logic [cfg_bits-1:0]       configuration,
    output logic                      io_isolate_o,
    output logic [user_macros-1:0]    macro_rst_no,
    output logic                      switch_busy_o
);

    localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    mpc_state_e              state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [cfg_bits-1:0]     pending, pend_nx, cfg_nx;
    logic                    range_err, rerr_nx;
    logic                    busy_err, berr_nx;
    logic                    term;
    logic                    ctrl_wr, status_wr;
    logic [WB_data_bits-1:0] wr_data;
    logic                    iso_nx;
    logic [user_macros-1:0]  mrst_nx;

    // Active-low reset vector with only the selected macro held in reset.
    function automatic logic [user_macros-1:0] rst_mask(input logic [cfg_bits-1:0] idx);
        logic [user_macros-1:0] m;
        for (int i = 0; i < user_macros; i++) begin
            m[i] = (idx != cfg_bits'(i));
        end
        return m;
    endfunction

    mpc_cfg_wb_regs #(
        .cfg_bits       (cfg_bits),
        .WB_data_bits   (WB_data_bits),
        .WB_addr_bits   (WB_addr_bits),
        .WB_select_bits (WB_select_bits),
        .CFG_BASE       (CFG_BASE)
    ) u_regs (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .pending       (pending),
        .configuration (configuration),
        .busy          (switch_busy_o),
        .range_err     (range_err),
        .busy_err      (busy_err),
        .ctrl_wr       (ctrl_wr),
        .status_wr     (status_wr),
        .wr_data       (wr_data)
    );

    assign term          = (cnt == CNT_W'(GUARD_CYCLES - 1));
    assign switch_busy_o = (state != ST_IDLE);

    // Next state: timer-driven transitions first, then the register write
    // is judged against the post-transition state.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cfg_nx   = configuration;
        pend_nx  = pending;
        rerr_nx  = range_err;
        berr_nx  = busy_err;
        case (state)
            ST_DRAIN: begin
                if (!wbs_cyc_i) begin
                    state_nx = ST_ISOLATE;
                    cnt_nx   = '0;
                end
            end
            ST_ISOLATE: begin
                if (term) begin
                    state_nx = ST_SWITCH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                cfg_nx   = pending;
                state_nx = ST_RELEASE;
                cnt_nx   = '0;
            end
            ST_RELEASE: begin
                if (term) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (status_wr) begin
            if (wr_data[STAT_RANGE_ERR_BIT]) rerr_nx = 1'b0;
            if (wr_data[STAT_BUSY_ERR_BIT])  berr_nx = 1'b0;
        end
        if (ctrl_wr) begin
            if (state_nx != ST_IDLE) begin
                berr_nx = 1'b1;
            end else if (wr_data >= WB_data_bits'(user_macros)) begin
                rerr_nx = 1'b1;
            end else if (wr_data != WB_data_bits'(cfg_nx)) begin
                pend_nx  = wr_data[cfg_bits-1:0];
                state_nx = ST_DRAIN;
                cnt_nx   = '0;
            end
        end
        iso_nx  = (state_nx == ST_ISOLATE) || (state_nx == ST_SWITCH) ||
                  (state_nx == ST_RELEASE);
        mrst_nx = ((state_nx == ST_ISOLATE) || (state_nx == ST_RELEASE)) ?
                  rst_mask(cfg_nx) : '1;
    end

    // FSM state, guard counter, select registers and registered sideband outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            configuration <= '0;
            pending       <= '0;
            range_err     <= 1'b0;
            busy_err      <= 1'b0;
            io_isolate_o  <= 1'b0;
            macro_rst_no  <= '1;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            configuration <= cfg_nx;
            pending       <= pend_nx;
            range_err     <= rerr_nx;
            busy_err      <= berr_nx;
            io_isolate_o  <= iso_nx;
            macro_rst_no  <= mrst_nx;
        end
    end

endmodule

// File: tb/tb_mpc_cfg_ctrl.sv
// Bench for mpc_cfg_ctrl: directed Wishbone transactions, with a scoreboard
// of expected read data and expected isolation pulse lengths.
module tb_mpc_cfg_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_w, adr;
    logic        ack;
    logic [31:0] dat_r;
    logic [1:0]  configuration;
    logic        io_isolate;
    logic [3:0]  macro_rst_n;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int          iso_q[$];
    int          iso_run = 0;
    int          hold_iso, hold_idle;

    mpc_cfg_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (dat_w),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat_r),
        .configuration (configuration),
        .io_isolate_o  (io_isolate),
        .macro_rst_no  (macro_rst_n),
        .switch_busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    // Read data monitor: every ack pops one expected word.
    always @(negedge clk) begin
        if (ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack data %h expected no ack", dat_r);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dat_r !== e) begin
                    errors++;
                    $display("FAIL read_data actual %h expected %h", dat_r, e);
                end
            end
        end else if (dat_r !== 32'h0) begin
            checks++;
            errors++;
            $display("FAIL dat_idle actual %h expected 0", dat_r);
        end
    end

    // Isolation monitor: each completed high pulse pops one expected length.
    always @(negedge clk) begin
        if (io_isolate) begin
            iso_run++;
        end else if (iso_run > 0) begin
            checks++;
            if (iso_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_isolate length %0d expected none", iso_run);
            end else begin
                int e;
                e = iso_q.pop_front();
                if (iso_run != e) begin
                    errors++;
                    $display("FAIL isolate_len actual %0d expected %0d", iso_run, e);
                end
            end
            iso_run = 0;
        end
    end

    task automatic wb_xfer(input logic w, input logic [1:0] off, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input int hold, input bit keep_stb);
        int  n;
        bit  got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; dat_w = wd;
        adr = BASE | {28'h0, off, 2'b00};
        exp_q.push_back(w ? 32'h0 : exp_rd);
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (ack) got = 1'b1;
        end
        if (!got) void'(exp_q.pop_back());
        checks++;
        if (!got || n != 1) begin
            errors++;
            $display("FAIL ack_latency actual %0d cycles expected 1", n);
        end
        if (!keep_stb) stb = 1'b0;
        we = 1'b0;
        hold_iso = 0; hold_idle = 0;
        repeat (hold) begin
            @(negedge clk);
            if (io_isolate) hold_iso++;
            if (!busy) hold_idle++;
        end
        stb = 1'b0; cyc = 1'b0;
    endtask

    initial begin
        int cnt_old, cnt_new, cnt_bad, last_old, first_new, nack, waited;
        rst_n = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_w = 32'h0; adr = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_cfg", 32'(configuration), 32'h0);
        chk("reset_mrst", 32'(macro_rst_n), 32'hF);
        chk("reset_iso", 32'(io_isolate), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_ack", 32'(ack), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Post-reset readback and reserved offsets
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0, 0, 1'b0);
        chk("cfg_after_reset", 32'(configuration), 32'h0);
        chk("mrst_after_reset", 32'(macro_rst_n), 32'hF);
        wb_xfer(1'b0, 2'd0, 32'h0, 32'h0, 0, 1'b0);
        wb_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
        wb_xfer(1'b0, 2'd3, 32'h0, 32'h0, 0, 1'b0);
        wb_xfer(1'b0, 2'd2, 32'h0, 32'h0, 0, 1'b0);

        // Outside the window: no ack
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h10;
        nack = 0;
        repeat (4) begin @(negedge clk); if (ack) nack++; end
        cyc = 1'b0; stb = 1'b0;
        chk("no_ack_outside", 32'(nack), 32'h0);

        // Switch 0 -> 2
        iso_q.push_back(9);
        wb_xfer(1'b1, 2'd0, 32'd2, 32'h0, 0, 1'b0);
        cnt_old = 0; cnt_new = 0; cnt_bad = 0; last_old = -1; first_new = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (macro_rst_n == 4'b1110) begin cnt_old++; last_old = i; end
            else if (macro_rst_n == 4'b1011) begin cnt_new++; if (first_new < 0) first_new = i; end
            else if (macro_rst_n != 4'b1111) cnt_bad++;
        end
        chk("old_rst_cycles", 32'(cnt_old), 32'd4);
        chk("new_rst_cycles", 32'(cnt_new), 32'd4);
        chk("other_rst_cycles", 32'(cnt_bad), 32'd0);
        chk("rst_gap", 32'(first_new - last_old), 32'd2);
        chk("cfg_after_switch", 32'(configuration), 32'd2);
        chk("busy_after_switch", 32'(busy), 32'd0);
        wb_xfer(1'b0, 2'd0, 32'h0, 32'd2, 0, 1'b0);

        // Out-of-range request and W1C clear
        wb_xfer(1'b1, 2'd0, 32'd5, 32'h0, 0, 1'b0);
        chk("busy_after_range", 32'(busy), 32'd0);
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0202, 0, 1'b0);
        chk("cfg_after_range", 32'(configuration), 32'd2);
        wb_xfer(1'b1, 2'd1, 32'h0000_0200, 32'h0, 0, 1'b0);
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0002, 0, 1'b0);

        // Request equal to current select is a no-op
        wb_xfer(1'b1, 2'd0, 32'd2, 32'h0, 0, 1'b0);
        chk("busy_after_same", 32'(busy), 32'd0);

        // Write during ISOLATE is discarded and flagged; STATUS readable mid-switch
        iso_q.push_back(9);
        wb_xfer(1'b1, 2'd0, 32'd3, 32'h0, 0, 1'b0);
        wb_xfer(1'b1, 2'd0, 32'd1, 32'h0, 0, 1'b0);
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0502, 0, 1'b0);
        repeat (14) @(negedge clk);
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0403, 0, 1'b0);
        chk("cfg_after_busy_err", 32'(configuration), 32'd3);
        wb_xfer(1'b1, 2'd1, 32'h0000_0400, 32'h0, 0, 1'b0);
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0003, 0, 1'b0);

        // Strobe held after ack must not be acked again
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0003, 3, 1'b1);

        // Cycle held in DRAIN, then a request landing on the RELEASE terminal edge
        iso_q.push_back(9);
        wb_xfer(1'b1, 2'd0, 32'd1, 32'h0, 10, 1'b0);
        chk("drain_iso_cycles", 32'(hold_iso), 32'd0);
        chk("drain_idle_cycles", 32'(hold_idle), 32'd0);
        iso_q.push_back(9);
        repeat (8) @(negedge clk);
        wb_xfer(1'b1, 2'd0, 32'd3, 32'h0, 0, 1'b0);
        repeat (14) @(negedge clk);
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0000_0003, 0, 1'b0);
        chk("cfg_after_terminal_hit", 32'(configuration), 32'd3);

        // Reset during RELEASE
        iso_q.push_back(6);
        wb_xfer(1'b1, 2'd0, 32'd2, 32'h0, 0, 1'b0);
        waited = 0;
        while (configuration != 2'd2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("reach_release", 32'(configuration), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cfg", 32'(configuration), 32'h0);
        chk("abort_iso", 32'(io_isolate), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_mrst", 32'(macro_rst_n), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        wb_xfer(1'b0, 2'd1, 32'h0, 32'h0, 0, 1'b0);
        wb_xfer(1'b0, 2'd0, 32'h0, 32'h0, 0, 1'b0);

        repeat (4) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("iso_q_drained", 32'(iso_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
